// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-ready handshake and a wrapping retired-instruction counter.
module multicycle_ctrl #(
  parameter int          W       = 16,
  parameter logic [2:0]  ALU_ADD = 3'b000,
  parameter logic [2:0]  ALU_SUB = 3'b001
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [3:0]   Opcode,
  input  logic         Zero,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic [1:0]   PCSrc,
  output logic         IRWrite,
  output logic         IorD,
  output logic         MemRead,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         RegDst,
  output logic         MemToReg,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [2:0]   ALUOp,
  output logic [2:0]   State,
  output logic         Halted,
  output logic         IllegalOp,
  output logic [W-1:0] RetiredCount
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         retire;

  logic is_r, is_addi, is_ld, is_st;
  logic is_beq, is_jmp, is_ill;

  assign is_r    = ~Opcode[3];
  assign is_ld   = (Opcode == 4'b1000);
  assign is_st   = (Opcode == 4'b1001);
  assign is_beq  = (Opcode == 4'b1010);
  assign is_jmp  = (Opcode == 4'b1011);
  assign is_addi = (Opcode == 4'b1100);
  // 1111 never reaches EXEC; grouping it here keeps the decode complete
  assign is_ill  = (Opcode[3:2] == 2'b11) & ~is_addi;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:  if (MemReady) state_d = DECODE;
      DECODE: state_d = (Opcode == 4'hF) ? HALT : EXEC;
      EXEC: begin
        if (is_r | is_addi) begin
          state_d = WB;
        end else if (is_ld | is_st) begin
          state_d = MEM;
        end else begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      MEM: begin
        if (MemReady) begin
          if (is_ld) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign cnt_d = retire ? cnt_q + W'(1) : cnt_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = ALU_ADD;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    if (Reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: ALUSrcB = 2'b10;
        EXEC: begin
          unique case (1'b1)
            is_r: begin
              ALUSrcA = 1'b1;
              ALUOp   = Opcode[2:0];
            end
            is_addi, is_ld, is_st: begin
              ALUSrcA = 1'b1;
              ALUSrcB = 2'b10;
            end
            is_beq: begin
              ALUSrcA = 1'b1;
              ALUOp   = ALU_SUB;
              PCSrc   = 2'b01;
              PCWrite = Zero;
            end
            is_jmp: begin
              PCSrc   = 2'b10;
              PCWrite = 1'b1;
            end
            is_ill: IllegalOp = 1'b1;
          endcase
        end
        MEM: begin
          IorD     = 1'b1;
          MemRead  = is_ld;
          MemWrite = is_st;
        end
        WB: begin
          RegWrite = 1'b1;
          RegDst   = is_r;
          MemToReg = is_ld;
        end
        HALT:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign State        = state_q;
  assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model with
// randomized opcodes, memory wait states and Zero, checked every cycle.
module tb_multicycle_ctrl;

  localparam int TW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [3:0]    Opcode = '0;
  logic          Zero = 1'b0;
  logic          MemReady = 1'b0;
  logic          PCWrite;
  logic [1:0]    PCSrc;
  logic          IRWrite;
  logic          IorD;
  logic          MemRead;
  logic          MemWrite;
  logic          RegWrite;
  logic          RegDst;
  logic          MemToReg;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [2:0]    ALUOp;
  logic [2:0]    State;
  logic          Halted;
  logic          IllegalOp;
  logic [TW-1:0] RetiredCount;

  always #5 Clock = ~Clock;

  multicycle_ctrl #(.W(TW)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode),
    .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .State(State), .Halted(Halted), .IllegalOp(IllegalOp),
    .RetiredCount(RetiredCount)
  );

  typedef enum int {K_RST, K_F, K_D, K_E, K_M, K_W, K_H} kind_e;

  typedef struct packed {
    logic [2:0]    st;
    logic          pcw;
    logic [1:0]    pcsrc;
    logic          irw;
    logic          iord;
    logic          mrd;
    logic          mwr;
    logic          rw;
    logic          rd;
    logic          m2r;
    logic          asa;
    logic [1:0]    asb;
    logic [2:0]    aluop;
    logic          hlt;
    logic          ill;
    logic [TW-1:0] cnt;
  } exp_t;

  exp_t expq[$];
  exp_t ce, ca, pe;
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;

  // Expected outputs for one cycle of an instruction, from its class
  function automatic exp_t model(kind_e k, logic [3:0] op,
                                 logic z, logic mr, int ret);
    exp_t e;
    e = '0;
    if (k == K_RST) return e;
    e.cnt = TW'(ret);
    case (k)
      K_F: begin
        e.st  = 3'd0;
        e.mrd = 1'b1;
        e.asb = 2'b01;
        e.irw = mr;
        e.pcw = mr;
      end
      K_D: begin
        e.st  = 3'd1;
        e.asb = 2'b10;
      end
      K_E: begin
        e.st = 3'd2;
        if (op < 4'd8) begin
          e.asa   = 1'b1;
          e.aluop = op[2:0];
        end else if (op == 4'd8 || op == 4'd9 || op == 4'd12) begin
          e.asa = 1'b1;
          e.asb = 2'b10;
        end else if (op == 4'd10) begin
          e.asa   = 1'b1;
          e.aluop = 3'b001;
          e.pcsrc = 2'b01;
          e.pcw   = z;
        end else if (op == 4'd11) begin
          e.pcsrc = 2'b10;
          e.pcw   = 1'b1;
        end else begin
          e.ill = 1'b1;
        end
      end
      K_M: begin
        e.st   = 3'd3;
        e.iord = 1'b1;
        e.mrd  = (op == 4'd8);
        e.mwr  = (op == 4'd9);
      end
      K_W: begin
        e.st  = 3'd4;
        e.rw  = 1'b1;
        e.rd  = (op < 4'd8);
        e.m2r = (op == 4'd8);
      end
      K_H: begin
        e.st  = 3'd5;
        e.hlt = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge Clock) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      ca = {State, PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite,
            RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp,
            Halted, IllegalOp, RetiredCount};
      checks++;
      if (ca !== ce) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h",
                 $time, ca, ce);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive at posedge+1, return at posedge+6
  task automatic cyc(kind_e k, logic [3:0] op, int mr, int z = -1);
    logic m;
    @(posedge Clock);
    #1;
    m        = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    Reset    = (k != K_RST);
    Opcode   = (k inside {K_D, K_E, K_M, K_W}) ? op : 4'($urandom);
    Zero     = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
    MemReady = m;
    expq.push_back(model(k, Opcode, Zero, m, retired));
    #5;
  endtask

  task automatic instr(logic [3:0] op, int fw, int mw, int z = -1);
    repeat (fw) cyc(K_F, op, 0);
    cyc(K_F, op, 1);
    cyc(K_D, op, -1);
    if (op == 4'd15) begin
      repeat (3) cyc(K_H, op, -1);
      return;
    end
    cyc(K_E, op, -1, z);
    if (op == 4'd8 || op == 4'd9) begin
      repeat (mw) cyc(K_M, op, 0);
      cyc(K_M, op, 1);
      if (op == 4'd9) begin
        retired++;
        return;
      end
    end
    if (op < 4'd9 || op == 4'd12) cyc(K_W, op, -1);
    retired++;
  endtask

  task automatic do_reset(int n);
    retired = 0;
    repeat (n) cyc(K_RST, 4'd0, -1);
  endtask

  initial begin
    logic [3:0] rop;
    do_reset(2);
    chk("rst_state", State, 0);
    chk("rst_cnt", RetiredCount, 0);
    chk("rst_memread", MemRead, 0);

    pe = model(K_E, 4'b0010, 1'b0, 1'b1, 0);
    chk("model_rtype_aluop", pe.aluop, 3'b010);
    pe = model(K_W, 4'b0010, 1'b0, 1'b1, 0);
    chk("model_rtype_wb", {pe.rw, pe.rd, pe.m2r}, 3'b110);
    pe = model(K_E, 4'b1010, 1'b1, 1'b1, 0);
    chk("model_beq_z1", {pe.pcw, pe.pcsrc}, 3'b101);
    pe = model(K_E, 4'b1010, 1'b0, 1'b1, 0);
    chk("model_beq_z0", {pe.pcw, pe.pcsrc}, 3'b001);

    instr(4'b0010, 0, 0);
    cyc(K_F, 4'd0, 0);
    chk("rtype_retired", RetiredCount, 1);

    instr(4'b1000, 0, 3);
    cyc(K_F, 4'd0, 0);
    chk("load_retired", RetiredCount, 2);

    instr(4'b1010, 0, 0, 1);
    instr(4'b1010, 0, 0, 0);
    cyc(K_F, 4'd0, 0);
    chk("beq_retired", RetiredCount, 4);

    cyc(K_F, 4'd13, 1);
    cyc(K_D, 4'd13, -1);
    cyc(K_E, 4'd13, -1);
    chk("illegal_pulse", {IllegalOp, PCWrite, RegWrite, MemWrite}, 4'b1000);
    retired++;
    cyc(K_F, 4'd0, 0);
    chk("illegal_retired", RetiredCount, 5);

    instr(4'b1111, 1, 0);
    repeat (5) cyc(K_H, 4'd0, -1);
    chk("halt_sticky", Halted, 1);
    chk("halt_cnt_frozen", RetiredCount, 5);
    do_reset(1);

    cyc(K_F, 4'd8, 1);
    cyc(K_D, 4'd8, -1);
    cyc(K_E, 4'd8, -1);
    cyc(K_M, 4'd8, 0);
    cyc(K_M, 4'd8, 0);
    do_reset(1);
    chk("rst_mid_mem", {State, MemRead, IorD}, 0);
    cyc(K_F, 4'd0, 0);
    chk("rst_mid_mem_cnt", RetiredCount, 0);

    repeat (15) instr(4'b1011, 0, 0);
    cyc(K_F, 4'd0, 0);
    chk("wrap_before", RetiredCount, 15);
    instr(4'b1011, 0, 0);
    cyc(K_F, 4'd0, 0);
    chk("wrap_after", RetiredCount, 0);

    repeat (400) begin
      rop = 4'($urandom);
      instr(rop, $urandom_range(0, 2), $urandom_range(0, 3));
      if (rop == 4'd15) do_reset($urandom_range(1, 2));
    end

    @(posedge Clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
